// File: rtl/md_pkg.sv
// Shared op codes and sizing helpers for the multiply/divide unit.
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  function automatic int md_cnt_width(input int mult_lat, input int div_lat);
    int m;
    m = (mult_lat > div_lat) ? mult_lat : div_lat;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational HI/LO result for a latched MULT/MULTU/DIV/DIVU operation.
module md_calc
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  md_op_e             op_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] hl_o
);

  logic                 is_signed;
  logic                 a_neg;
  logic                 b_neg;
  logic [2*WIDTH-1:0]   a_ext;
  logic [2*WIDTH-1:0]   b_ext;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [WIDTH-1:0]     div_b;
  logic [WIDTH-1:0]     uq;
  logic [WIDTH-1:0]     ur;
  logic [WIDTH-1:0]     q;
  logic [WIDTH-1:0]     r;

  always_comb begin
    is_signed = (op_i == MD_MULT) || (op_i == MD_DIV);
    a_neg     = is_signed & a_i[WIDTH-1];
    b_neg     = is_signed & b_i[WIDTH-1];

    // Low 2*WIDTH bits of the sign-extended product equal the signed product.
    a_ext = {{WIDTH{a_neg}}, a_i};
    b_ext = {{WIDTH{b_neg}}, b_i};
    prod  = a_ext * b_ext;

    // Magnitude divide; MIN_INT / -1 falls out as quotient MIN_INT, remainder 0.
    a_mag = a_neg ? -a_i : a_i;
    b_mag = b_neg ? -b_i : b_i;
    div_b = (b_i == '0) ? WIDTH'(1) : b_mag;
    uq    = a_mag / div_b;
    ur    = a_mag % div_b;
    q     = (a_neg ^ b_neg) ? -uq : uq;
    r     = a_neg ? -ur : ur;

    hl_o = '0;
    case (op_i)
      MD_MULT, MD_MULTU: hl_o = prod;
      MD_DIV, MD_DIVU:   hl_o = (b_i == '0) ? {a_i, {WIDTH{1'b1}}} : {r, q};
      default:           hl_o = '0;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle MULT/DIV unit with architectural HI/LO and a registered busy flag.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = md_cnt_width(MULT_LAT, DIV_LAT);

  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q;
  md_op_e             op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [2*WIDTH-1:0] hl_next;

  md_calc #(.WIDTH(WIDTH)) u_calc (
    .op_i (op_q),
    .a_i  (a_q),
    .b_i  (b_q),
    .hl_o (hl_next)
  );

  always_comb begin
    cnt_d = cnt_q;
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        hi_d = hl_next[2*WIDTH-1:WIDTH];
        lo_d = hl_next[WIDTH-1:0];
      end
    end else if (start) begin
      case (md_op_e'(md_op))
        MD_MTHI: hi_d = A;
        MD_MTLO: lo_d = A;
        MD_MULT, MD_MULTU: begin
          op_d  = md_op_e'(md_op);
          a_d   = A;
          b_d   = B;
          cnt_d = CW'(MULT_LAT);
        end
        MD_DIV, MD_DIVU: begin
          op_d  = md_op_e'(md_op);
          a_d   = A;
          b_d   = B;
          cnt_d = CW'(DIV_LAT);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      op_q   <= MD_MULT;
      a_q    <= '0;
      b_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= (cnt_d != '0);
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit with hand-computed HI/LO results and busy timing.
module tb_md_unit;
  import md_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int errs;
  int checks;
  int cyc;

  md_unit #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Issue one op; optionally raise a second start at busy cycle inj_cyc.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int inj_cyc, input logic [2:0] inj_op, input logic [31:0] inj_a,
                        output int cycles);
    logic [31:0] hi_pre;
    logic [31:0] lo_pre;
    int n;
    hi_pre = hi;
    lo_pre = lo;
    start = 1'b1;
    md_op = op;
    A = a;
    B = b;
    @(posedge clk); #1;
    start = 1'b0;
    A = ~a;
    B = ~b;
    n = 0;
    while (busy && n < 40) begin
      n++;
      check_val("hold_hi", hi, hi_pre);
      check_val("hold_lo", lo, lo_pre);
      if (n == inj_cyc) begin
        start = 1'b1;
        md_op = inj_op;
        A = inj_a;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    cycles = n;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    errs   = 0;
    checks = 0;
    reset  = 1'b0;
    start  = 1'b0;
    md_op  = 3'd0;
    A      = '0;
    B      = '0;
    #12;
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_hi", hi, 32'd0);
    check_val("rst_lo", lo, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    run_op(MD_MULT, 32'hFFFFFFF6, 32'h00000064, 0, 3'd0, 32'd0, cyc);
    check_val("mult_cyc", cyc, 32'd5);
    check_val("mult_hi", hi, 32'hFFFFFFFF);
    check_val("mult_lo", lo, 32'hFFFFFC18);

    run_op(MD_MULTU, 32'hFFFFFFFF, 32'h00000002, 3, MD_MULT, 32'h00000003, cyc);
    check_val("multu_cyc", cyc, 32'd5);
    check_val("multu_hi", hi, 32'h00000001);
    check_val("multu_lo", lo, 32'hFFFFFFFE);

    run_op(MD_DIV, 32'hFFFFD82A, 32'h00000003, 0, 3'd0, 32'd0, cyc);
    check_val("div_cyc", cyc, 32'd10);
    check_val("div_lo", lo, 32'hFFFFF2B9);
    check_val("div_hi", hi, 32'hFFFFFFFF);

    run_op(MD_DIVU, 32'h00000064, 32'h00000007, 0, 3'd0, 32'd0, cyc);
    check_val("divu_lo", lo, 32'h0000000E);
    check_val("divu_hi", hi, 32'h00000002);

    run_op(MD_DIV, 32'h00000007, 32'hFFFFFFFE, 0, 3'd0, 32'd0, cyc);
    check_val("divneg_lo", lo, 32'hFFFFFFFD);
    check_val("divneg_hi", hi, 32'h00000001);

    run_op(MD_DIV, 32'h00000007, 32'h00000000, 0, 3'd0, 32'd0, cyc);
    check_val("div0_lo", lo, 32'hFFFFFFFF);
    check_val("div0_hi", hi, 32'h00000007);

    run_op(MD_DIVU, 32'h00000005, 32'h00000000, 0, 3'd0, 32'd0, cyc);
    check_val("divu0_lo", lo, 32'hFFFFFFFF);
    check_val("divu0_hi", hi, 32'h00000005);

    run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 0, 3'd0, 32'd0, cyc);
    check_val("ovf_lo", lo, 32'h80000000);
    check_val("ovf_hi", hi, 32'h00000000);

    run_op(3'd6, 32'h11111111, 32'h22222222, 0, 3'd0, 32'd0, cyc);
    check_val("rsvd_cyc", cyc, 32'd0);
    check_val("rsvd_hi", hi, 32'h00000000);
    check_val("rsvd_lo", lo, 32'h80000000);

    run_op(MD_MTHI, 32'h12345678, 32'h0, 0, 3'd0, 32'd0, cyc);
    check_val("mthi_cyc", cyc, 32'd0);
    check_val("mthi_busy", {31'd0, busy}, 32'd0);
    check_val("mthi_hi", hi, 32'h12345678);
    check_val("mthi_lo", lo, 32'h80000000);

    run_op(MD_MULTU, 32'h00000002, 32'h00000003, 0, 3'd0, 32'd0, cyc);
    check_val("b2b1_lo", lo, 32'h00000006);
    check_val("b2b1_hi", hi, 32'h00000000);
    run_op(MD_DIVU, 32'h00000009, 32'h00000002, 3, MD_MTLO, 32'h0000AAAA, cyc);
    check_val("b2b2_cyc", cyc, 32'd10);
    check_val("b2b2_lo", lo, 32'h00000004);
    check_val("b2b2_hi", hi, 32'h00000001);

    start = 1'b1;
    md_op = MD_DIV;
    A = 32'h00000064;
    B = 32'h00000007;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("abort_busy_pre", {31'd0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check_val("abort_busy", {31'd0, busy}, 32'd0);
    check_val("abort_hi", hi, 32'd0);
    check_val("abort_lo", lo, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check_val("post_busy", {31'd0, busy}, 32'd0);
    check_val("post_hi", hi, 32'd0);
    check_val("post_lo", lo, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
